alu_mdu_control: RTL and testbench

//  Parametrised successor to the single-cycle ALU control decoder. Decodes {ALUOp, ALUFunction} into a
//  4-bit ALU operation code and adds a sequencer for multi-cycle MULT/MULTU/DIV/DIVU. The sequencer

---
 rtl/alu_mdu_control.sv | 181 ++++++++++++++++++
 tb/tb_alu_mdu_control.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_mdu_control.sv
// alu_mdu_control
//   Decodes {ALUOp, ALUFunction} into a 4-bit ALU operation code and sequences
//   multi-cycle MULT/MULTU/DIV/DIVU operations for the multiply-divide unit.
//   Optional feature macro: ALU_ILLEGAL_TRAP_EN (sticky illegal-selector flag).
module alu_mdu_control #(
  parameter int ALUOP_WIDTH = 3,
  parameter int FUNCT_WIDTH = 6,
  parameter int MUL_CYCLES  = 4,
  parameter int DIV_CYCLES  = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   valid_i,
  input  logic [ALUOP_WIDTH-1:0] ALUOp,
  input  logic [FUNCT_WIDTH-1:0] ALUFunction,
  output logic [3:0]             ALUOperation,
  output logic                   mdu_start,
  output logic                   mdu_busy,
  output logic                   stall,
  output logic                   hilo_we,
  output logic                   hilo_sel,
  output logic                   illegal_op
);

  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [ALUOP_WIDTH-1:0] OP_RTYPE = {ALUOP_WIDTH{1'b1}};
  localparam logic [ALUOP_WIDTH-1:0] OP_ADDI  = ALUOP_WIDTH'(3'b100);
  localparam logic [ALUOP_WIDTH-1:0] OP_ORI   = ALUOP_WIDTH'(3'b101);
  localparam logic [ALUOP_WIDTH-1:0] OP_LUI   = ALUOP_WIDTH'(3'b011);
  localparam logic [ALUOP_WIDTH-1:0] OP_ANDI  = ALUOP_WIDTH'(3'b110);

  localparam logic [FUNCT_WIDTH-1:0] FN_AND   = FUNCT_WIDTH'(6'b100100);
  localparam logic [FUNCT_WIDTH-1:0] FN_OR    = FUNCT_WIDTH'(6'b100101);
  localparam logic [FUNCT_WIDTH-1:0] FN_NOR   = FUNCT_WIDTH'(6'b100111);
  localparam logic [FUNCT_WIDTH-1:0] FN_ADD   = FUNCT_WIDTH'(6'b010100);
  localparam logic [FUNCT_WIDTH-1:0] FN_SLL   = FUNCT_WIDTH'(6'b000000);
  localparam logic [FUNCT_WIDTH-1:0] FN_SRL   = FUNCT_WIDTH'(6'b000010);
  localparam logic [FUNCT_WIDTH-1:0] FN_MULT  = FUNCT_WIDTH'(6'b011000);
  localparam logic [FUNCT_WIDTH-1:0] FN_MULTU = FUNCT_WIDTH'(6'b011001);
  localparam logic [FUNCT_WIDTH-1:0] FN_DIV   = FUNCT_WIDTH'(6'b011010);
  localparam logic [FUNCT_WIDTH-1:0] FN_DIVU  = FUNCT_WIDTH'(6'b011011);
  localparam logic [FUNCT_WIDTH-1:0] FN_MFHI  = FUNCT_WIDTH'(6'b010000);
  localparam logic [FUNCT_WIDTH-1:0] FN_MFLO  = FUNCT_WIDTH'(6'b010010);

  localparam logic [3:0] CODE_ILLEGAL = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  logic is_rtype;
  logic is_mul;
  logic is_div;
  logic is_mdu;
  logic is_hilo;
  logic issue;

  // Operation code lookup: R-type uses funct, everything else uses ALUOp.
  function automatic logic [3:0] decode_op(input logic [ALUOP_WIDTH-1:0] op,
                                           input logic [FUNCT_WIDTH-1:0] fn);
    logic [3:0] code;
    code = CODE_ILLEGAL;
    if (op == OP_RTYPE) begin
      case (fn)
        FN_AND:   code = 4'b0000;
        FN_OR:    code = 4'b0001;
        FN_NOR:   code = 4'b0010;
        FN_ADD:   code = 4'b0011;
        FN_SLL:   code = 4'b0100;
        FN_SRL:   code = 4'b0101;
        FN_MULT:  code = 4'b1010;
        FN_MULTU: code = 4'b1011;
        FN_DIV:   code = 4'b1100;
        FN_DIVU:  code = 4'b1101;
        FN_MFHI:  code = 4'b1110;
        FN_MFLO:  code = 4'b1110;
        default:  code = CODE_ILLEGAL;
      endcase
    end else begin
      case (op)
        OP_ADDI: code = 4'b0110;
        OP_ORI:  code = 4'b0111;
        OP_LUI:  code = 4'b1000;
        OP_ANDI: code = 4'b1001;
        default: code = CODE_ILLEGAL;
      endcase
    end
    return code;
  endfunction

  // Zero-latency decode and instruction class flags, independent of state.
  always_comb begin
    ALUOperation = decode_op(ALUOp, ALUFunction);
    is_rtype     = (ALUOp == OP_RTYPE);
    is_mul       = is_rtype && ((ALUFunction == FN_MULT) || (ALUFunction == FN_MULTU));
    is_div       = is_rtype && ((ALUFunction == FN_DIV)  || (ALUFunction == FN_DIVU));
    is_mdu       = is_mul || is_div;
    is_hilo      = is_rtype && ((ALUFunction == FN_MFHI) || (ALUFunction == FN_MFLO));
    hilo_sel     = is_rtype && (ALUFunction == FN_MFHI);
  end

  // Stall/issue: MDU ops wait out RUN; HI/LO reads also wait out DONE,
  // since the result is only written on that edge. Reset masks the pulse.
  always_comb begin
    stall     = valid_i && (((is_mdu || is_hilo) && (state == RUN)) ||
                            (is_hilo && (state == DONE)));
    issue     = valid_i && is_mdu && !stall && !reset;
    mdu_start = issue;
    mdu_busy  = (state != IDLE);
    hilo_we   = (state == DONE);
  end

  // Sequencer state and down-counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic: issue loads the counter, RUN counts to zero, DONE lasts one cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (issue) begin
          state_nxt = RUN;
          cnt_nxt   = is_mul ? CW'(MUL_CYCLES - 1) : CW'(DIV_CYCLES - 1);
        end
      end
      RUN: begin
        if (cnt == '0) begin
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      DONE: begin
        if (issue) begin
          state_nxt = RUN;
          cnt_nxt   = is_mul ? CW'(MUL_CYCLES - 1) : CW'(DIV_CYCLES - 1);
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

`ifdef ALU_ILLEGAL_TRAP_EN
  logic illegal_q;

  // Sticky flag: any valid instruction with an unmatched selector sets it until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal_q <= 1'b0;
    end else if (valid_i && (ALUOperation == CODE_ILLEGAL)) begin
      illegal_q <= 1'b1;
    end
  end

  assign illegal_op = illegal_q;
`else
  assign illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_alu_mdu_control.sv
// Directed testbench for alu_mdu_control (default parameters: MUL_CYCLES=4, DIV_CYCLES=32).
// Inputs change shortly after the falling edge; outputs are checked before the next rising edge.
module tb_alu_mdu_control;

  logic       clk;
  logic       reset;
  logic       valid_i;
  logic [2:0] ALUOp;
  logic [5:0] ALUFunction;
  logic [3:0] ALUOperation;
  logic       mdu_start;
  logic       mdu_busy;
  logic       stall;
  logic       hilo_we;
  logic       hilo_sel;
  logic       illegal_op;

  int errors = 0;
  int checks = 0;

  alu_mdu_control dut (
    .clk          (clk),
    .reset        (reset),
    .valid_i      (valid_i),
    .ALUOp        (ALUOp),
    .ALUFunction  (ALUFunction),
    .ALUOperation (ALUOperation),
    .mdu_start    (mdu_start),
    .mdu_busy     (mdu_busy),
    .stall        (stall),
    .hilo_we      (hilo_we),
    .hilo_sel     (hilo_sel),
    .illegal_op   (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance to the next cycle and apply new inputs.
  task automatic cyc(input logic v, input logic [2:0] op, input logic [5:0] fn);
    @(negedge clk);
    valid_i     = v;
    ALUOp       = op;
    ALUFunction = fn;
    #1;
  endtask

  typedef struct {
    logic [2:0] op;
    logic [5:0] fn;
    logic [3:0] code;
    logic       sel;
  } dvec_t;

  dvec_t dtab[18];

  initial begin
    dtab[0]  = '{3'b111, 6'b100100, 4'b0000, 1'b0};
    dtab[1]  = '{3'b111, 6'b100101, 4'b0001, 1'b0};
    dtab[2]  = '{3'b111, 6'b100111, 4'b0010, 1'b0};
    dtab[3]  = '{3'b111, 6'b010100, 4'b0011, 1'b0};
    dtab[4]  = '{3'b111, 6'b000000, 4'b0100, 1'b0};
    dtab[5]  = '{3'b111, 6'b000010, 4'b0101, 1'b0};
    dtab[6]  = '{3'b111, 6'b011000, 4'b1010, 1'b0};
    dtab[7]  = '{3'b111, 6'b011001, 4'b1011, 1'b0};
    dtab[8]  = '{3'b111, 6'b011010, 4'b1100, 1'b0};
    dtab[9]  = '{3'b111, 6'b011011, 4'b1101, 1'b0};
    dtab[10] = '{3'b111, 6'b010000, 4'b1110, 1'b1};
    dtab[11] = '{3'b111, 6'b010010, 4'b1110, 1'b0};
    dtab[12] = '{3'b100, 6'b000000, 4'b0110, 1'b0};
    dtab[13] = '{3'b101, 6'b000000, 4'b0111, 1'b0};
    dtab[14] = '{3'b011, 6'b000000, 4'b1000, 1'b0};
    dtab[15] = '{3'b110, 6'b000000, 4'b1001, 1'b0};
    dtab[16] = '{3'b111, 6'b111111, 4'b1111, 1'b0};
    dtab[17] = '{3'b000, 6'b010000, 4'b1111, 1'b0};

    // Reset state, with a MULT presented to confirm reset masks the start pulse
    reset = 1'b1; valid_i = 1'b1; ALUOp = 3'b111; ALUFunction = 6'b011000;
    #3;
    chk("rst_start", {7'd0, mdu_start}, 8'd0);
    chk("rst_busy",  {7'd0, mdu_busy},  8'd0);
    chk("rst_stall", {7'd0, stall},     8'd0);
    chk("rst_hilowe",{7'd0, hilo_we},   8'd0);
    chk("rst_illeg", {7'd0, illegal_op},8'd0);
    cyc(1'b0, 3'b111, 6'b0);
    cyc(1'b0, 3'b111, 6'b0);
    reset = 1'b0;

    // 1: decode sweep with valid_i low (no FSM effect, decode still driven)
    for (int i = 0; i < 18; i++) begin
      cyc(1'b0, dtab[i].op, dtab[i].fn);
      chk($sformatf("dec_code_%0d", i), {4'd0, ALUOperation}, {4'd0, dtab[i].code});
      chk($sformatf("dec_sel_%0d", i),  {7'd0, hilo_sel},     {7'd0, dtab[i].sel});
      chk($sformatf("dec_start_%0d", i),{7'd0, mdu_start},    8'd0);
    end

    // 2: MULT at T -> busy T+1..T+5, hilo_we only at T+5
    cyc(1'b1, 3'b111, 6'b011000);
    chk("mul_start", {7'd0, mdu_start}, 8'd1);
    chk("mul_stall", {7'd0, stall},     8'd0);
    chk("mul_busy0", {7'd0, mdu_busy},  8'd0);
    for (int k = 1; k <= 6; k++) begin
      cyc(1'b0, 3'b111, 6'b011000);
      chk($sformatf("mul_busy_%0d", k), {7'd0, mdu_busy}, {7'd0, (k <= 5)});
      chk($sformatf("mul_we_%0d", k),   {7'd0, hilo_we},  {7'd0, (k == 5)});
      chk($sformatf("mul_st_%0d", k),   {7'd0, mdu_start}, 8'd0);
    end

    // Non-MDU op while busy decodes and never stalls
    cyc(1'b1, 3'b111, 6'b011001);
    chk("mulu_start", {7'd0, mdu_start}, 8'd1);
    cyc(1'b1, 3'b111, 6'b100101);
    chk("busy_or_stall", {7'd0, stall}, 8'd0);
    chk("busy_or_code",  {4'd0, ALUOperation}, 8'h01);
    cyc(1'b1, 3'b111, 6'b011010);
    chk("busy_div_stall", {7'd0, stall},     8'd1);
    chk("busy_div_start", {7'd0, mdu_start}, 8'd0);
    for (int k = 3; k <= 6; k++) cyc(1'b0, 3'b111, 6'b0);
    chk("mulu_idle", {7'd0, mdu_busy}, 8'd0);

    // 3: DIV at T, MFLO from T+1 stalls through T+33, proceeds at T+34
    cyc(1'b1, 3'b111, 6'b011010);
    chk("div_start", {7'd0, mdu_start}, 8'd1);
    for (int k = 1; k <= 33; k++) begin
      cyc(1'b1, 3'b111, 6'b010010);
      chk($sformatf("div_stall_%0d", k), {7'd0, stall},   8'd1);
      chk($sformatf("div_we_%0d", k),    {7'd0, hilo_we}, {7'd0, (k == 33)});
    end
    cyc(1'b1, 3'b111, 6'b010010);
    chk("mflo_stall", {7'd0, stall},        8'd0);
    chk("mflo_code",  {4'd0, ALUOperation}, 8'h0e);
    chk("mflo_sel",   {7'd0, hilo_sel},     8'd0);
    chk("mflo_busy",  {7'd0, mdu_busy},     8'd0);

    // 4: MULT issued in DONE of a DIVU, back-to-back
    cyc(1'b1, 3'b111, 6'b011011);
    chk("divu_start", {7'd0, mdu_start}, 8'd1);
    for (int k = 1; k <= 32; k++) cyc(1'b0, 3'b111, 6'b0);
    cyc(1'b1, 3'b111, 6'b011000);
    chk("b2b_we",    {7'd0, hilo_we},   8'd1);
    chk("b2b_stall", {7'd0, stall},     8'd0);
    chk("b2b_start", {7'd0, mdu_start}, 8'd1);
    for (int k = 1; k <= 5; k++) begin
      cyc(1'b0, 3'b111, 6'b0);
      chk($sformatf("b2b_we_%0d", k), {7'd0, hilo_we}, {7'd0, (k == 5)});
    end

    // 5: reset pulse mid-RUN of DIV
    cyc(1'b1, 3'b111, 6'b011010);
    chk("rdiv_start", {7'd0, mdu_start}, 8'd1);
    for (int k = 1; k <= 5; k++) cyc(1'b0, 3'b111, 6'b0);
    chk("rdiv_busy_pre", {7'd0, mdu_busy}, 8'd1);
    reset = 1'b1;
    #1;
    chk("rdiv_busy_async", {7'd0, mdu_busy}, 8'd0);
    chk("rdiv_we_async",   {7'd0, hilo_we},  8'd0);
    #1;
    reset = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      cyc(1'b0, 3'b111, 6'b0);
      chk($sformatf("rdiv_quiet_%0d", k), {6'd0, mdu_busy, hilo_we}, 8'd0);
    end
    cyc(1'b1, 3'b111, 6'b011000);
    chk("rmul_start", {7'd0, mdu_start}, 8'd1);
    for (int k = 1; k <= 5; k++) begin
      cyc(1'b0, 3'b111, 6'b0);
      chk($sformatf("rmul_we_%0d", k), {7'd0, hilo_we}, {7'd0, (k == 5)});
    end

    // 6: illegal selector with valid_i
    chk("illeg_before", {7'd0, illegal_op}, 8'd0);
    cyc(1'b1, 3'b000, 6'b000000);
    chk("illeg_code", {4'd0, ALUOperation}, 8'h0f);
    chk("illeg_same", {7'd0, illegal_op}, 8'd0);
    cyc(1'b1, 3'b111, 6'b100100);
`ifdef ALU_ILLEGAL_TRAP_EN
    chk("illeg_set", {7'd0, illegal_op}, 8'd1);
    cyc(1'b0, 3'b111, 6'b0);
    cyc(1'b0, 3'b111, 6'b0);
    chk("illeg_sticky", {7'd0, illegal_op}, 8'd1);
`else
    chk("illeg_set", {7'd0, illegal_op}, 8'd0);
    cyc(1'b0, 3'b111, 6'b0);
    cyc(1'b0, 3'b111, 6'b0);
    chk("illeg_sticky", {7'd0, illegal_op}, 8'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
